intirvx_wb_arbiter: RTL

- Parametrised write-back stage for the intirvx core; successor to the fixed three-source write-back (ALU/MEM/CSR).
- Accepts results from NUM_CH execution channels over valid/ready handshakes and arbitrates one result per cycle.
- Drives a registered write-back bus to the register manager and reports exceptions.
- Adds selectable fixed-priority or round-robin arbitration, exception-first granting and a retired-instruction counter.

---
 rtl/intirvx_wb_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/intirvx_wb_arbiter.sv
// intirvx_wb_arbiter
//   Write-back stage for the intirvx core. NUM_CH execution channels offer
//   results over valid/ready. One result is granted per cycle, and the
//   granted result is registered onto the write-back bus one cycle later.
//   An excepting channel always wins, and the lowest-index excepting channel
//   is chosen. Otherwise arbitration is fixed priority (ARB_MODE=0) or round
//   robin (ARB_MODE=1).
//
// Ports
//   clk         core clock
//   rst         asynchronous reset, active-high
//   ch_valid    per-channel result valid
//   ch_ready    per-channel grant (combinational, one-hot or zero)
//   ch_data     per-channel result, channel i at [i*XLEN +: XLEN]
//   ch_rd       per-channel destination, channel i at [i*RD_W +: RD_W]
//   ch_exc      per-channel exception flag
//   wb_valid    register-file write enable (registered)
//   wb_rd       write destination (registered)
//   wb_data     write data (registered)
//   exc_valid   exception reported this cycle (registered)
//   exc_ch      index of the excepting channel (registered)
//   retire_cnt  results retired without exception, wraps modulo 2^CNT_W
module intirvx_wb_arbiter #(
  parameter int NUM_CH   = 3,
  parameter int XLEN     = 32,
  parameter int RD_W     = 5,
  parameter int ARB_MODE = 1,
  parameter int CNT_W    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*XLEN-1:0]     ch_data,
  input  logic [NUM_CH*RD_W-1:0]     ch_rd,
  input  logic [NUM_CH-1:0]          ch_exc,
  output logic                       wb_valid,
  output logic [RD_W-1:0]            wb_rd,
  output logic [XLEN-1:0]            wb_data,
  output logic                       exc_valid,
  output logic [$clog2(NUM_CH)-1:0]  exc_ch,
  output logic [CNT_W-1:0]           retire_cnt
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_idx;
  logic             grant_any;
  logic             grant_exc;
  logic [XLEN-1:0]  data_arr [NUM_CH];
  logic [RD_W-1:0]  rd_arr   [NUM_CH];
  logic [XLEN-1:0]  sel_data;
  logic [RD_W-1:0]  sel_rd;
  logic [IDX_W-1:0] ptr_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign data_arr[g] = ch_data[g*XLEN +: XLEN];
    assign rd_arr[g]   = ch_rd[g*RD_W +: RD_W];
  end

  // Loops run from high index to low so the last match, which is the
  // lowest index or the nearest channel to rr_ptr, takes effect.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    grant_exc = 1'b0;
    rr_idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_valid[IDX_W'(i)] && ch_exc[IDX_W'(i)]) begin
        grant_idx = IDX_W'(i);
        grant_any = 1'b1;
        grant_exc = 1'b1;
      end
    end
    if (!grant_exc) begin
      if (ARB_MODE == 0) begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (ch_valid[IDX_W'(i)]) begin
            grant_idx = IDX_W'(i);
            grant_any = 1'b1;
          end
        end
      end else begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          rr_idx = IDX_W'((int'(rr_ptr) + k) % NUM_CH);
          if (ch_valid[rr_idx]) begin
            grant_idx = rr_idx;
            grant_any = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    ch_ready = '0;
    if (grant_any && !rst) ch_ready[grant_idx] = 1'b1;
  end

  assign sel_data = data_arr[grant_idx];
  assign sel_rd   = rd_arr[grant_idx];
  assign ptr_next = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_ch     <= '0;
      retire_cnt <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (grant_any) begin
        rr_ptr <= ptr_next;
        if (grant_exc) begin
          exc_valid <= 1'b1;
          exc_ch    <= grant_idx;
        end else begin
          retire_cnt <= retire_cnt + CNT_W'(1);
          // A write to x0 still retires the instruction, but it does not pulse the bus.
          if (sel_rd != '0) begin
            wb_valid <= 1'b1;
            wb_rd    <= sel_rd;
            wb_data  <= sel_data;
          end
        end
      end
    end
  end

endmodule
